neuron_operand_loader: RTL and testbench
========================================

Name: neuron_operand_loader

Overview:
- Upstream feeder for the fully parallel fixed-point neuron.
- Accepts a serial valid/ready stream of N (input, weight) beats followed by one bias beat, and buffers them in registers.
- Presents the complete frame as parallel flattened vectors with a valid/ready handshake.
- Decouples the narrow serial source (DMA/testbench/previous layer) from the N-wide neuron datapath.

Parameters:
- N, 2, number of neuron inputs (>=1).
- QM, 12, integer bits of input/bias words.
- QN, 20, fraction bits of input/bias words.
- WM, 6, integer bits of weight words.
- WN, 10, fraction bits of weight words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  source beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  QM+QN  input word (beats 0..N-1) or bias (beat N), signed
- s_weight  in  WM+WN  weight word (beats 0..N-1); ignored on bias beat
- s_last  in  1  marks bias beat; must be 1 exactly on beat N
- vec_in  out  N*(QM+QN)  inputs; element k at bits [k*(QM+QN) +: QM+QN]
- vec_weights  out  N*(WM+WN)  weights; element k at [k*(WM+WN) +: WM+WN]
- vec_bias  out  QM+QN  bias
- vec_valid  out  1  full frame available
- vec_ready  in  1  consumer takes frame
- err  out  1  sticky framing error
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async, rst_n=0): state LOAD, beat counter 0, vec_in/vec_weights/vec_bias = 0, vec_valid = 0, err = 0, s_ready = 0 during reset then 1 in LOAD.
- Beat accepted iff s_valid & s_ready on a rising clk edge.
- States:
  - LOAD: s_ready = 1. Accepted beat with cnt<N and s_last=0 writes s_data to element cnt of vec_in and s_weight to element cnt of vec_weights; cnt++. Accepted beat at cnt==N with s_last=1 writes s_data to vec_bias, cnt←0, next state PRESENT.
  - PRESENT: s_ready = 0, vec_valid = 1. All vec_* outputs held stable. On vec_valid & vec_ready → LOAD next cycle with vec_valid = 0.
- Latency: vec_valid rises the cycle after the bias beat is accepted. After the consumer handshake, s_ready is 1 on the next cycle. Peak throughput is one frame per N+2 cycles.
- No combinational path from s_valid to s_ready or from vec_ready to vec_valid. s_ready is a pure function of state.
- Framing errors, both checked on accepted beats only:
  - s_last=1 at cnt<N (early last).
  - s_last=0 at cnt==N (missing last).
  - Either error: err←1, frame aborted, cnt←0, stay in LOAD. Partially written elements may hold stale data; they are overwritten by the next frame. vec_valid is never asserted for an aborted frame.
- err is sticky until err_clr=1 (cleared next edge). If err_clr and a new error occur in the same cycle, err stays 1 (set wins).
- Data is stored verbatim; there is no arithmetic, sign extension or saturation. Widths must match the neuron.
- Reset mid-frame or in PRESENT discards everything; the source must restart the frame from beat 0.
- vec_ready while not in PRESENT is ignored.

Optional Feature:
- Macro: NEURON_LOADER_WEIGHT_REUSE_EN.
- When defined:
  - Adds input port reuse_w (1 bit), sampled together with every accepted weight beat.
  - A beat with reuse_w=1 writes only vec_in; vec_weights element cnt keeps its previous value.
  - Lets the same weight set serve many input frames without reloading.
- When undefined: the port is absent and every data beat writes both vec_in and vec_weights.

Test Plan:
- N=2, beats (0x0010_0000, 0x0400), (0xFFF0_0000, 0x0200), bias 0x0008_0000 with s_last, vec_ready=1 → vec_valid one cycle after the bias beat; vec_in = {0xFFF00000, 0x00100000}, vec_weights = {0x0200, 0x0400}, vec_bias = 0x00080000; s_ready=1 on the following cycle.
- Backpressure: frame loaded, vec_ready=0 for 5 cycles → vec_valid stays 1, outputs stable, s_ready=0 throughout. Beats offered by the source are not accepted. vec_ready=1 → transfer completes, then reload.
- Early last: s_last=1 on beat 0 → err=1, no vec_valid. A following correct frame loads and presents normally with err still 1. err_clr=1 → err=0 next cycle.
- Missing last: beat 2 with s_last=0 → err=1, counter restarts. The next beat is treated as element 0.
- Async reset asserted after beat 1 of a frame → all outputs 0 immediately. After release, a full new frame presents correctly.
- With NEURON_LOADER_WEIGHT_REUSE_EN: frame 1 loads weights 0x0400/0x0200. Frame 2 sent with reuse_w=1 and s_weight=0xFFFF → vec_weights still {0x0200, 0x0400}, vec_in updated.

Source files
------------

// File: rtl/neuron_operand_loader.sv
// neuron_operand_loader
// Buffers a serial valid/ready stream of N (input, weight) beats plus one
// bias beat, then presents the whole frame as parallel flattened vectors to
// the fixed-point neuron through a valid/ready handshake.
//
// Optional build macro: NEURON_LOADER_WEIGHT_REUSE_EN adds the reuse_w input.
// When reuse_w is 1 on a data beat, only vec_in is written and the stored
// weight element is kept.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   source beat handshake (s_ready registered, decoded from state)
//   s_data            input word (beats 0..N-1) or bias (beat N)
//   s_weight          weight word (beats 0..N-1), ignored on the bias beat
//   s_last            marks the bias beat
//   reuse_w           (optional) keep stored weight for this beat
//   vec_in            N inputs, element k at [k*(QM+QN) +: QM+QN]
//   vec_weights       N weights, element k at [k*(WM+WN) +: WM+WN]
//   vec_bias          bias word
//   vec_valid         full frame presented
//   vec_ready         consumer accepts frame
//   err               sticky framing error
//   err_clr           synchronous clear of err (a same-cycle new error wins)
module neuron_operand_loader #(
    parameter int unsigned N  = 2,
    parameter int unsigned QM = 12,
    parameter int unsigned QN = 20,
    parameter int unsigned WM = 6,
    parameter int unsigned WN = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [QM+QN-1:0]       s_data,
    input  logic [WM+WN-1:0]       s_weight,
    input  logic                   s_last,
`ifdef NEURON_LOADER_WEIGHT_REUSE_EN
    input  logic                   reuse_w,
`endif
    output logic [N*(QM+QN)-1:0]   vec_in,
    output logic [N*(WM+WN)-1:0]   vec_weights,
    output logic [QM+QN-1:0]       vec_bias,
    output logic                   vec_valid,
    input  logic                   vec_ready,
    output logic                   err,
    input  logic                   err_clr
);

    localparam int unsigned DW    = QM + QN;
    localparam int unsigned WW    = WM + WN;
    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic {
        LOAD    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               s_ready_q, s_ready_d;
    logic               vec_valid_q, vec_valid_d;
    logic               err_q, err_d;
    logic               wr_elem;
    logic               wr_bias;
    logic               wr_weight;
    logic               err_set;
    logic               accept;

    // State, counter, handshake and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            cnt         <= '0;
            s_ready_q   <= 1'b0;
            vec_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            s_ready_q   <= s_ready_d;
            vec_valid_q <= vec_valid_d;
            err_q       <= err_d;
        end
    end

    // Next-state, beat decode and framing check
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        wr_elem    = 1'b0;
        wr_bias    = 1'b0;
        err_set    = 1'b0;
        accept     = s_valid & s_ready_q;

        unique case (state)
            LOAD: begin
                if (accept) begin
                    if (cnt == CNT_W'(N)) begin
                        cnt_next = '0;
                        if (s_last) begin
                            wr_bias    = 1'b1;
                            next_state = PRESENT;
                        end else begin
                            err_set = 1'b1;
                        end
                    end else if (s_last) begin
                        err_set  = 1'b1;
                        cnt_next = '0;
                    end else begin
                        wr_elem  = 1'b1;
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            PRESENT: begin
                if (vec_ready) begin
                    next_state = LOAD;
                end
            end
            default: next_state = LOAD;
        endcase

        // Handshake flags are registered decodes of the upcoming state
        s_ready_d   = (next_state == LOAD);
        vec_valid_d = (next_state == PRESENT);
        err_d       = err_set | (err_q & ~err_clr);
    end

`ifdef NEURON_LOADER_WEIGHT_REUSE_EN
    assign wr_weight = wr_elem & ~reuse_w;
`else
    assign wr_weight = wr_elem;
`endif

    // Frame buffer; elements are stored verbatim
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_in      <= '0;
            vec_weights <= '0;
            vec_bias    <= '0;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                if (wr_elem && (cnt == CNT_W'(k))) begin
                    vec_in[k*DW +: DW] <= s_data;
                end
                if (wr_weight && (cnt == CNT_W'(k))) begin
                    vec_weights[k*WW +: WW] <= s_weight;
                end
            end
            if (wr_bias) begin
                vec_bias <= s_data;
            end
        end
    end

    assign s_ready   = s_ready_q;
    assign vec_valid = vec_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_neuron_operand_loader.sv
// Directed bench for neuron_operand_loader (N=2, Q12.20 data, Q6.10 weights).
module tb_neuron_operand_loader;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [15:0] s_weight;
    logic        s_last;
    logic        reuse_w;
    logic [63:0] vec_in;
    logic [31:0] vec_weights;
    logic [31:0] vec_bias;
    logic        vec_valid;
    logic        vec_ready;
    logic        err;
    logic        err_clr;

    int tests;
    int fails;

    neuron_operand_loader #(.N(2), .QM(12), .QN(20), .WM(6), .WN(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_weight    (s_weight),
        .s_last      (s_last),
`ifdef NEURON_LOADER_WEIGHT_REUSE_EN
        .reuse_w     (reuse_w),
`endif
        .vec_in      (vec_in),
        .vec_weights (vec_weights),
        .vec_bias    (vec_bias),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .err         (err),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, wait (bounded) for s_ready, and complete the transfer
    task automatic send_beat(input logic [31:0] d, input logic [15:0] w, input logic last);
        int n;
        s_valid  = 1'b1;
        s_data   = d;
        s_weight = w;
        s_last   = last;
        n = 0;
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        if (n == 20) check("s_ready_timeout", 64'(s_ready), 64'd1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_weight = '0;
        s_last   = 1'b0;
        reuse_w  = 1'b0;
        vec_ready = 1'b0;
        err_clr  = 1'b0;

        // Reset state
        step();
        check("rst_s_ready",   64'(s_ready),   64'd0);
        check("rst_vec_valid", 64'(vec_valid), 64'd0);
        check("rst_err",       64'(err),       64'd0);
        check("rst_vec_in",    vec_in,         64'd0);
        rst_n = 1'b1;
        step();
        check("load_s_ready", 64'(s_ready), 64'd1);

        // Basic frame with consumer always ready
        vec_ready = 1'b1;
        send_beat(32'h0010_0000, 16'h0400, 1'b0);
        send_beat(32'hFFF0_0000, 16'h0200, 1'b0);
        check("b_no_valid_early", 64'(vec_valid), 64'd0);
        send_beat(32'h0008_0000, 16'h0000, 1'b1);
        check("b_vec_valid",   64'(vec_valid), 64'd1);
        check("b_vec_in",      vec_in,         64'hFFF0_0000_0010_0000);
        check("b_vec_weights", 64'(vec_weights), 64'h0200_0400);
        check("b_vec_bias",    64'(vec_bias),  64'h0008_0000);
        check("b_s_ready_lo",  64'(s_ready),   64'd0);
        step();
        check("b_valid_drop",  64'(vec_valid), 64'd0);
        check("b_s_ready_hi",  64'(s_ready),   64'd1);

        // Backpressure: frame held while the source keeps offering beats
        vec_ready = 1'b0;
        send_beat(32'h0000_0001, 16'h0011, 1'b0);
        send_beat(32'h0000_0002, 16'h0022, 1'b0);
        send_beat(32'h0000_0003, 16'h0000, 1'b1);
        s_valid  = 1'b1;
        s_data   = 32'hDEAD_BEEF;
        s_weight = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            check("bp_vec_valid", 64'(vec_valid), 64'd1);
            check("bp_s_ready",   64'(s_ready),   64'd0);
            check("bp_vec_in",    vec_in,         64'h0000_0002_0000_0001);
            check("bp_vec_w",     64'(vec_weights), 64'h0022_0011);
            step();
        end
        s_valid   = 1'b0;
        check("bp_vec_bias", 64'(vec_bias), 64'h0000_0003);
        vec_ready = 1'b1;
        step();
        check("bp_release_valid", 64'(vec_valid), 64'd0);
        check("bp_release_ready", 64'(s_ready),   64'd1);
        check("bp_held_vec_in",   vec_in,         64'h0000_0002_0000_0001);

        // Early last on beat 0
        send_beat(32'h0000_AAAA, 16'h0001, 1'b1);
        check("el_err",       64'(err),       64'd1);
        check("el_no_valid",  64'(vec_valid), 64'd0);
        check("el_s_ready",   64'(s_ready),   64'd1);
        vec_ready = 1'b0;
        send_beat(32'h0000_0011, 16'h0101, 1'b0);
        send_beat(32'h0000_0022, 16'h0202, 1'b0);
        send_beat(32'h0000_0033, 16'h0000, 1'b1);
        check("el_next_valid", 64'(vec_valid), 64'd1);
        check("el_next_vec_in", vec_in,        64'h0000_0022_0000_0011);
        check("el_err_sticky", 64'(err),       64'd1);
        vec_ready = 1'b1;
        err_clr   = 1'b1;
        step();
        err_clr   = 1'b0;
        check("el_err_cleared", 64'(err), 64'd0);

        // Missing last: third data-looking beat aborts the frame
        send_beat(32'h0000_0001, 16'h0001, 1'b0);
        send_beat(32'h0000_0002, 16'h0002, 1'b0);
        send_beat(32'h0000_0003, 16'h0003, 1'b0);
        check("ml_err",      64'(err),       64'd1);
        check("ml_no_valid", 64'(vec_valid), 64'd0);
        vec_ready = 1'b0;
        send_beat(32'h0000_0055, 16'h0005, 1'b0);
        send_beat(32'h0000_0066, 16'h0006, 1'b0);
        send_beat(32'h0000_0077, 16'h0000, 1'b1);
        check("ml_restart_valid",  64'(vec_valid),   64'd1);
        check("ml_restart_vec_in", vec_in,           64'h0000_0066_0000_0055);
        check("ml_restart_vec_w",  64'(vec_weights), 64'h0006_0005);
        check("ml_restart_bias",   64'(vec_bias),    64'h0000_0077);
        vec_ready = 1'b1;
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Asynchronous reset in mid-frame
        send_beat(32'h0000_0123, 16'h0007, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_vec_in",    vec_in,           64'd0);
        check("ar_vec_w",     64'(vec_weights), 64'd0);
        check("ar_vec_bias",  64'(vec_bias),    64'd0);
        check("ar_vec_valid", 64'(vec_valid),   64'd0);
        check("ar_s_ready",   64'(s_ready),     64'd0);
        step();
        rst_n = 1'b1;
        step();
        vec_ready = 1'b0;
        send_beat(32'h0010_0000, 16'h0400, 1'b0);
        send_beat(32'hFFF0_0000, 16'h0200, 1'b0);
        send_beat(32'h0008_0000, 16'h0000, 1'b1);
        check("ar_frame_valid", 64'(vec_valid),   64'd1);
        check("ar_frame_in",    vec_in,           64'hFFF0_0000_0010_0000);
        check("ar_frame_w",     64'(vec_weights), 64'h0200_0400);
        check("ar_frame_bias",  64'(vec_bias),    64'h0008_0000);
        vec_ready = 1'b1;
        step();

`ifdef NEURON_LOADER_WEIGHT_REUSE_EN
        // Second frame reuses the stored weights
        vec_ready = 1'b0;
        reuse_w   = 1'b1;
        send_beat(32'h0000_1111, 16'hFFFF, 1'b0);
        send_beat(32'h0000_2222, 16'hFFFF, 1'b0);
        send_beat(32'h0000_3333, 16'hFFFF, 1'b1);
        reuse_w   = 1'b0;
        check("rw_valid",   64'(vec_valid),   64'd1);
        check("rw_vec_w",   64'(vec_weights), 64'h0200_0400);
        check("rw_vec_in",  vec_in,           64'h0000_2222_0000_1111);
        check("rw_bias",    64'(vec_bias),    64'h0000_3333);
        vec_ready = 1'b1;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
